// File: rtl/ysyx_icache_pkg.sv
// ============================================================================
// Module      : ysyx_icache_pkg
// Description : Shared FSM state encoding and address-field width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte offset within a line: 2 bits of byte-in-word plus the word index.
  function automatic int off_bits(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Word counter width; kept at least one bit so single-word lines still elaborate.
  function automatic int word_bits(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_icache_if.sv
// ============================================================================
// Module      : ysyx_icache_if
// Description : Fetch request/response, bus read, flush and counter signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_icache_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_inst;
  logic [ADDR_W-1:0] resp_pc;
  logic              mem_arvalid;
  logic              mem_arready;
  logic [ADDR_W-1:0] mem_araddr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              flush;
  logic [31:0]       perf_hit;
  logic [31:0]       perf_miss;

  modport slave (
    input  req_valid, req_addr, resp_ready, mem_arready, mem_rvalid, mem_rdata, flush,
    output req_ready, resp_valid, resp_inst, resp_pc, mem_arvalid, mem_araddr,
           perf_hit, perf_miss
  );

  modport master (
    output req_valid, req_addr, resp_ready, mem_arready, mem_rvalid, mem_rdata, flush,
    input  req_ready, resp_valid, resp_inst, resp_pc, mem_arvalid, mem_araddr,
           perf_hit, perf_miss
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_icache_array.sv
// ============================================================================
// Module      : ysyx_icache_array
// Description : Direct-mapped tag/valid/data storage, async read, sync write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_icache_array
  import ysyx_icache_pkg::*;
#(
  parameter  int SETS       = 16,
  parameter  int LINE_WORDS = 4,
  parameter  int TAG_W      = 24,
  localparam int c_IDX_W    = idx_bits(SETS),
  localparam int c_WORD_W   = word_bits(LINE_WORDS)
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_clr_all,
  input  wire logic [c_IDX_W-1:0]  i_rd_idx,
  input  wire logic [c_WORD_W-1:0] i_rd_word,
  output logic                     o_rd_valid,
  output logic [TAG_W-1:0]         o_rd_tag,
  output logic [31:0]              o_rd_data,
  input  wire logic                i_data_we,
  input  wire logic [c_IDX_W-1:0]  i_wr_idx,
  input  wire logic [c_WORD_W-1:0] i_wr_word,
  input  wire logic [31:0]         i_wr_data,
  input  wire logic                i_tag_we,
  input  wire logic [TAG_W-1:0]    i_wr_tag,
  input  wire logic                i_wr_valid
);

  logic [31:0]      r_data [SETS][LINE_WORDS];
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [SETS-1:0]  r_valid;

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

  always_ff @(posedge clk) begin
    if (i_data_we) r_data[i_wr_idx][i_wr_word] <= i_wr_data;
    if (i_tag_we)  r_tag[i_wr_idx] <= i_wr_tag;
  end

  // A clear in the same cycle as a tag write wins, so a flushed fill stays invalid.
  always_ff @(posedge clk) begin
    if (rst || i_clr_all) r_valid <= '0;
    else if (i_tag_we)    r_valid[i_wr_idx] <= i_wr_valid;
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_icache.sv
// ============================================================================
// Module      : ysyx_icache
// Description : Direct-mapped blocking instruction cache with line refill.
//               Define YSYX_ICACHE_PERF_EN to build the hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_icache
  import ysyx_icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input wire logic       clk,
  input wire logic       rst,
  ysyx_icache_if.slave   bus
);

  localparam int c_OFF    = off_bits(LINE_WORDS);
  localparam int c_IDX_W  = idx_bits(SETS);
  localparam int c_WORD_W = word_bits(LINE_WORDS);
  localparam int c_TAG_W  = ADDR_W - c_OFF - c_IDX_W;

  state_t              r_state;
  logic                r_resp_valid;
  logic [31:0]         r_resp_inst;
  logic [ADDR_W-1:0]   r_resp_pc;
  logic                r_arvalid;
  logic                r_wait;
  logic [c_WORD_W-1:0] r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_flushed;

  logic                w_rd_valid;
  logic [c_TAG_W-1:0]  w_rd_tag;
  logic [31:0]         w_rd_data;

  wire logic [c_TAG_W-1:0]  w_req_tag  = c_TAG_W'(bus.req_addr >> (c_OFF + c_IDX_W));
  wire logic [c_IDX_W-1:0]  w_req_idx  = c_IDX_W'(bus.req_addr >> c_OFF);
  wire logic [c_WORD_W-1:0] w_req_word = c_WORD_W'((bus.req_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
  wire logic [c_TAG_W-1:0]  w_fill_tag  = c_TAG_W'(r_addr >> (c_OFF + c_IDX_W));
  wire logic [c_IDX_W-1:0]  w_fill_idx  = c_IDX_W'(r_addr >> c_OFF);
  wire logic [c_WORD_W-1:0] w_fill_word = c_WORD_W'((r_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
  wire logic [ADDR_W-1:0]   w_line_base = (r_addr >> c_OFF) << c_OFF;

  wire logic w_req_ready = (r_state == ST_IDLE) | ((r_state == ST_RESP) & bus.resp_ready);
  wire logic w_accept    = bus.req_valid & w_req_ready;
  wire logic w_hit       = w_rd_valid & (w_rd_tag == w_req_tag) & ~bus.flush;
  wire logic w_rfire     = (r_state == ST_FILL) & r_wait & bus.mem_rvalid;
  wire logic w_last      = (r_cnt == c_WORD_W'(LINE_WORDS - 1));

  ysyx_icache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (c_TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_clr_all  (bus.flush),
    .i_rd_idx   (w_req_idx),
    .i_rd_word  (w_req_word),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_data_we  (w_rfire),
    .i_wr_idx   (w_fill_idx),
    .i_wr_word  (r_cnt),
    .i_wr_data  (bus.mem_rdata),
    .i_tag_we   (w_rfire & w_last),
    .i_wr_tag   (w_fill_tag),
    .i_wr_valid (~(r_flushed | bus.flush))
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_inst  <= '0;
      r_resp_pc    <= '0;
      r_arvalid    <= 1'b0;
      r_wait       <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_flushed    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            if (w_hit) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_inst  <= w_rd_data;
              r_resp_pc    <= bus.req_addr;
            end else begin
              r_state      <= ST_FILL;
              r_resp_valid <= 1'b0;
              r_addr       <= bus.req_addr;
              r_cnt        <= '0;
              r_arvalid    <= 1'b1;
              r_wait       <= 1'b0;
              r_flushed    <= 1'b0;
            end
          end else if (r_state == ST_RESP && bus.resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        ST_FILL: begin
          if (bus.flush) r_flushed <= 1'b1;
          if (r_arvalid && bus.mem_arready) begin
            r_arvalid <= 1'b0;
            r_wait    <= 1'b1;
          end
          if (w_rfire) begin
            r_wait <= 1'b0;
            // Capture the requested word in flight; no second read port needed.
            if (r_cnt == w_fill_word) r_resp_inst <= bus.mem_rdata;
            if (w_last) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_pc    <= r_addr;
            end else begin
              r_cnt     <= r_cnt + c_WORD_W'(1);
              r_arvalid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_inst   = r_resp_inst;
  assign bus.resp_pc     = r_resp_pc;
  assign bus.mem_arvalid = r_arvalid;
  assign bus.mem_araddr  = w_line_base | (ADDR_W'(r_cnt) << 2);

`ifdef YSYX_ICACHE_PERF_EN
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
    end else if (w_accept) begin
      if (w_hit) r_perf_hit  <= r_perf_hit + 32'd1;
      else       r_perf_miss <= r_perf_miss + 32'd1;
    end
  end

  assign bus.perf_hit  = r_perf_hit;
  assign bus.perf_miss = r_perf_miss;
`else
  assign bus.perf_hit  = '0;
  assign bus.perf_miss = '0;
`endif

endmodule

`default_nettype wire
